// File: rtl/telemetry_pkg.sv
// Shared types and helpers for the IMU telemetry frame serializer.
package telemetry_pkg;

    localparam int         FRAME_LEN         = 15;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE,
        DONE
    } state_t;

    // Six raw channels in frame order, accel_x in the most significant bits.
    typedef struct packed {
        logic [9:0] ax;
        logic [9:0] ay;
        logic [9:0] az;
        logic [9:0] gx;
        logic [9:0] gy;
        logic [9:0] gz;
    } snapshot_t;

    // Bytes 0..13 of a frame. The checksum byte comes from the caller's
    // running sum, so index 14 and above return zero here.
    function automatic logic [7:0] frame_byte(
        input logic [3:0] idx,
        input logic [7:0] seqNum,
        input snapshot_t  snap,
        input logic [7:0] syncByte
    );
        logic [9:0] chan;
        logic [7:0] result;
        case (idx)
            4'd2, 4'd3:   chan = snap.ax;
            4'd4, 4'd5:   chan = snap.ay;
            4'd6, 4'd7:   chan = snap.az;
            4'd8, 4'd9:   chan = snap.gx;
            4'd10, 4'd11: chan = snap.gy;
            4'd12, 4'd13: chan = snap.gz;
            default:      chan = '0;
        endcase
        if (idx == 4'd0)
            result = syncByte;
        else if (idx == 4'd1)
            result = seqNum;
        else if (idx <= 4'd13)
            result = idx[0] ? chan[7:0] : {6'b0, chan[9:8]};
        else
            result = 8'h00;
        return result;
    endfunction

endpackage

// File: rtl/telemetry_framer_sender.sv
// Pushes one byte through the UART transmit/is_transmitting handshake.
//
//   state     | meaning
//   IDLE      | nothing pending; start hands over a byte
//   SEND      | byte held, waiting for the UART to go idle before pulsing
//   WAIT_BUSY | transmit pulsed, waiting for the UART to go busy (timed)
//   WAIT_IDLE | UART is sending our byte, waiting for it to finish
module uart_byte_sender
    import telemetry_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       start,
    input  logic [7:0] txData,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       done,
    output logic       timeout
);

    localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

    state_t             state, stateNext;
    logic [7:0]         holdByte;
    logic [TIMER_W-1:0] ackTimer;
    logic               fire;

    // Next state, transmit request and completion flags
    always_comb begin
        stateNext = state;
        fire      = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!is_transmitting) begin
                        fire      = 1'b1;
                        stateNext = WAIT_BUSY;
                    end else begin
                        stateNext = SEND;
                    end
                end
            end
            SEND: begin
                if (!is_transmitting) begin
                    fire      = 1'b1;
                    stateNext = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (is_transmitting) begin
                    stateNext = WAIT_IDLE;
                end else if (ackTimer == '0) begin
                    // No acknowledge: report it and treat the byte as sent
                    timeout   = 1'b1;
                    done      = 1'b1;
                    stateNext = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!is_transmitting) begin
                    done      = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Registered transmit pulse, byte latch and acknowledge down-counter
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            transmit <= 1'b0;
            tx_byte  <= '0;
            holdByte <= '0;
            ackTimer <= '0;
        end else begin
            transmit <= fire;
            if (fire) begin
                tx_byte  <= (state == IDLE) ? txData : holdByte;
                ackTimer <= TIMER_W'(ACK_TIMEOUT - 1);
            end else if (state == WAIT_BUSY && ackTimer != '0) begin
                ackTimer <= ackTimer - TIMER_W'(1);
            end
            if (state == IDLE && start)
                holdByte <= txData;
        end
    end

endmodule

// File: rtl/telemetry_framer.sv
// Snapshots six IMU channels on a selected sample edge and serialises them
// as a 15-byte frame (sync, seq, 12 data bytes, checksum) to the UART.
//
//   state     | meaning
//   IDLE      | no frame in progress; a selected, enabled edge snapshots
//   SEND      | hand byte idx to the sender (one cycle)
//   WAIT_BUSY | byte idx in flight inside the sender
//   DONE      | last byte finished; bump seq and drop busy
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int         SAMPLE_W    = 10,
    parameter int         DECIMATE    = 1,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] accel_x,
    input  logic [SAMPLE_W-1:0] accel_y,
    input  logic [SAMPLE_W-1:0] accel_z,
    input  logic [SAMPLE_W-1:0] gyro_x,
    input  logic [SAMPLE_W-1:0] gyro_y,
    input  logic [SAMPLE_W-1:0] gyro_z,
    output logic                transmit,
    output logic [7:0]          tx_byte,
    input  logic                is_transmitting,
    output logic                busy,
    output logic [7:0]          seq,
    output logic [7:0]          drop_count,
    output logic                ack_err
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);
    localparam logic [7:0] DEC_LAST = 8'(DECIMATE - 1);

    state_t     state, stateNext;
    snapshot_t  snap;
    logic       svQ, sampleEdge, selected, takeSnap, start;
    logic       senderDone, senderTimeout;
    logic [7:0] decCnt, sum, curByte;
    logic [3:0] idx;

    assign sampleEdge = sample_valid & ~svQ;
    assign selected   = sampleEdge && (decCnt == DEC_LAST);
    assign takeSnap   = selected && enable && (state == IDLE);
    assign curByte    = (idx == LAST_IDX) ? 8'h00 - sum
                                          : frame_byte(idx, seq, snap, SYNC_BYTE);

    uart_byte_sender #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) sender (
        .CLOCK_50       (CLOCK_50),
        .RESET_N        (RESET_N),
        .start          (start),
        .txData         (curByte),
        .is_transmitting(is_transmitting),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .done           (senderDone),
        .timeout        (senderTimeout)
    );

    // Frame sequencing: next state and byte hand-off
    always_comb begin
        stateNext = state;
        start     = 1'b0;
        case (state)
            IDLE:      if (takeSnap) stateNext = SEND;
            SEND: begin
                start     = 1'b1;
                stateNext = WAIT_BUSY;
            end
            WAIT_BUSY: if (senderDone) stateNext = (idx == LAST_IDX) ? DONE : SEND;
            DONE:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Edge detect, decimation, snapshot, byte index, checksum and status
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            svQ        <= 1'b0;
            decCnt     <= '0;
            snap       <= '0;
            idx        <= '0;
            sum        <= '0;
            busy       <= 1'b0;
            seq        <= '0;
            drop_count <= '0;
            ack_err    <= 1'b0;
        end else begin
            svQ <= sample_valid;
            if (sampleEdge)
                decCnt <= selected ? 8'd0 : decCnt + 8'd1;
            if (takeSnap) begin
                snap <= {accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z};
                idx  <= '0;
                sum  <= '0;
                busy <= 1'b1;
            end
            if (selected && busy && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            // Sync and checksum bytes are excluded from the running sum
            if (start && idx != 4'd0 && idx != LAST_IDX)
                sum <= sum + curByte;
            if (state == WAIT_BUSY && senderDone && idx != LAST_IDX)
                idx <= idx + 4'd1;
            if (senderTimeout)
                ack_err <= 1'b1;
            if (state == DONE) begin
                seq  <= seq + 8'd1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
Sits between the IMU interface and the on-board UART, directly upstream of the UART.
On each new IMU sample it snapshots the six raw 10-bit channels and serialises them as a fixed 15-byte frame: sync, sequence number, 12 data bytes, checksum.
It drives the UART byte handshake (transmit / tx_byte / is_transmitting) and replaces the single-byte test sender used on the phone link.

Parameters:
SAMPLE_W, 10, width of each IMU channel (frame layout below is fixed for 10).
DECIMATE, 1, send one frame per DECIMATE sample edges (1..255).
SYNC_BYTE, 8'hA5, first byte of every frame.
ACK_TIMEOUT, 16, cycles to wait for is_transmitting to rise after a transmit pulse.

Ports:
CLOCK_50  in  1  system clock, 50 MHz.
RESET_N  in  1  asynchronous active-low reset.
enable  in  1  high = frames may start; sampled only in IDLE.
sample_valid  in  1  IMU data-valid level; its rising edge marks a new sample.
accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z  in  10 each  raw IMU channels, stable while sample_valid is high.
transmit  out  1  one-cycle request to UART.
tx_byte  out  8  byte to send; valid in the transmit cycle.
is_transmitting  in  1  UART busy.
busy  out  1  high from snapshot until the last byte completes.
seq  out  8  sequence number of the next frame.
drop_count  out  8  saturating count of samples dropped while busy.
ack_err  out  1  sticky; set on handshake timeout.

Behaviour:
- Reset values: transmit=0, tx_byte=0, busy=0, seq=0, drop_count=0, ack_err=0. State=IDLE, decimation counter=0, edge register=0. Reset mid-frame aborts the frame immediately; no partial-frame recovery.
- Edge detect: sv_q <= sample_valid. Edge = sample_valid & ~sv_q.
- Decimation counter increments on every edge, whatever the state. When it reaches DECIMATE-1 it wraps to 0 and the edge is "selected".
- Selected edge in IDLE with enable=1: snapshot all six channels and set busy the next cycle.
- Selected edge while busy: drop_count += 1, saturating at 255. The frame in progress is unaffected.
- Selected edge with enable=0: ignored; not counted as a drop.
- Frame bytes (idx 0..14):
  - 0: SYNC_BYTE.
  - 1: seq.
  - 2..13: for channels in order ax, ay, az, gx, gy, gz, high byte {6'b0, d[9:8]} then low byte d[7:0].
  - 14: checksum = (0 - sum of bytes 1..13) mod 256, so bytes 1..14 sum to 0 mod 256.
- Checksum accumulates as bytes are issued; no separate pass.
- FSM states:
  - IDLE: waits for a snapshot, then goes to SEND with idx=0.
  - SEND: if is_transmitting=0, drive transmit=1 for exactly one cycle with tx_byte=byte[idx], then go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: on is_transmitting=1 go to WAIT_IDLE. If ACK_TIMEOUT cycles elapse first, set ack_err and treat the byte as sent.
  - WAIT_IDLE: on is_transmitting=0, idx += 1. If idx was 14, go to DONE; else go to SEND.
  - DONE: seq += 1 (wraps 255->0), busy=0, go to IDLE.
- Latency: edge at cycle N → snapshot at N+1 → first transmit pulse at N+2, provided is_transmitting is low.
- tx_byte holds its last value between pulses. transmit is never high on two consecutive cycles.
- Deasserting enable mid-frame does not stop the current frame.
- Snapshot registers change only in the IDLE→SEND transition.

Decomposition:
- Package telemetry_pkg holds:
  - FRAME_LEN = 15
  - default SYNC_BYTE
  - state enum {IDLE, SEND, WAIT_BUSY, WAIT_IDLE, DONE}
  - function frame_byte(idx, seq, snapshot)
- One sub-module, uart_byte_sender, owns the SEND/WAIT_BUSY/WAIT_IDLE handshake and the timeout.
  - Inputs: start, byte, is_transmitting.
  - Outputs: transmit, tx_byte, done, timeout.
- The top FSM sequences idx, the checksum and seq.

Test Plan:
- Single frame with accel_x=10'h3FF, all others 0, and a UART model (busy 1 cycle after transmit, for 20 cycles) → 15 bytes A5 00 03 FF 00×10 FE; seq becomes 1; busy falls after the last byte.
- Two frames, second with gyro_z=10'h155 → seq byte 01; last data bytes 01 55; checksum = (0 - (0x01+0x01+0x55)) mod 256 = 0xA9.
- DECIMATE=4 with 8 sample edges spaced wider than one frame → exactly 2 frames, on edges 4 and 8.
- Three edges during one frame, DECIMATE=1 → drop_count=3; the frame's payload equals the first snapshot.
- UART model never raises is_transmitting → ack_err=1 after 16 cycles per byte; the frame still completes and seq increments.
- RESET_N low for 1 cycle at byte 7 → transmit=0 and busy=0 immediately, seq=0; the next sample edge produces a full frame starting with A5 00.
